// File: rtl/record_serializer_pkg.sv
// rtl/record_serializer_pkg.sv - shared defaults and state type for the record serializer
package record_serializer_pkg;

    localparam int DEF_WORD_SIZE    = 8;
    localparam int DEF_RECORD_WORDS = 16;

    typedef enum logic [0:0] {
        ST_EMPTY  = 1'b0,
        ST_STREAM = 1'b1
    } ser_state_e;

endpackage

// File: rtl/record_serializer_if.sv
// rtl/record_serializer_if.sv - record-in / word-out handshake bundle for the record serializer
interface record_serializer_if
    import record_serializer_pkg::*;
#(
    parameter int WordSize    = DEF_WORD_SIZE,
    parameter int RecordWords = DEF_RECORD_WORDS
);
    localparam int RecordSizeBits = WordSize * RecordWords;
    localparam int RecordPosSize  = $clog2(RecordWords);

    logic                        rec_valid;
    logic [RecordSizeBits-1:0]   rec_data;
    logic                        rec_ready;
    logic                        word_req;
    logic [WordSize-1:0]         word_out;
    logic                        word_valid;
    logic [RecordPosSize+1:0]    words_left;
    logic [7:0]                  underrun_count;

    modport master (
        output rec_valid, rec_data, word_req,
        input  rec_ready, word_out, word_valid, words_left, underrun_count
    );

    modport slave (
        input  rec_valid, rec_data, word_req,
        output rec_ready, word_out, word_valid, words_left, underrun_count
    );

endinterface

// File: rtl/record_serializer.sv
// rtl/record_serializer.sv - double-buffered record-to-word serializer with show-ahead output
module record_serializer
    import record_serializer_pkg::*;
#(
    parameter int WordSize    = DEF_WORD_SIZE,
    parameter int RecordWords = DEF_RECORD_WORDS
) (
    input  logic               clk,
    input  logic               rst_n,
    record_serializer_if.slave bus
);
    localparam int RecordSizeBits = WordSize * RecordWords;
    localparam int RecordPosSize  = $clog2(RecordWords);
    localparam int LeftSize       = RecordPosSize + 2;
    localparam logic [RecordPosSize-1:0] LastIdx = RecordPosSize'(RecordWords - 1);
    localparam logic [0:0] EMPTY  = ST_EMPTY;
    localparam logic [0:0] STREAM = ST_STREAM;

    logic [0:0]                state;
    logic [RecordSizeBits-1:0] act;
    logic [RecordSizeBits-1:0] hold;
    logic                      hold_full;
    logic [RecordPosSize-1:0]  idx;
    logic [7:0]                underrun;

    logic accept;
    logic pop;
    logic pop_last;

    assign accept   = bus.rec_valid && !hold_full;
    assign pop      = bus.word_req && (state == STREAM);
    assign pop_last = pop && (idx == LastIdx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            act       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            idx       <= '0;
            underrun  <= '0;
        end else begin
            if (bus.word_req && (state != STREAM) && (underrun != 8'hFF))
                underrun <= underrun + 8'd1;

            if (state == EMPTY) begin
                if (accept) begin
                    act   <= bus.rec_data;
                    idx   <= '0;
                    state <= STREAM;
                end
            end else if (pop_last) begin
                // Last word leaves: promote hold, else take the incoming record, else drain.
                idx <= '0;
                if (hold_full) begin
                    act       <= hold;
                    hold_full <= accept;
                    if (accept)
                        hold <= bus.rec_data;
                end else if (accept) begin
                    act <= bus.rec_data;
                end else begin
                    state <= EMPTY;
                end
            end else begin
                if (pop)
                    idx <= idx + 1'b1;
                if (accept) begin
                    hold      <= bus.rec_data;
                    hold_full <= 1'b1;
                end
            end
        end
    end

    logic [WordSize-1:0] act_words [RecordWords];

    for (genvar i = 0; i < RecordWords; i++) begin : g_word
        assign act_words[i] = act[i*WordSize +: WordSize];
    end

    logic [LeftSize-1:0] left_act;
    logic [LeftSize-1:0] left_hold;

    always_comb begin
        left_act  = '0;
        left_hold = '0;
        if (state == STREAM)
            left_act = LeftSize'(RecordWords) - LeftSize'(idx);
        if (hold_full)
            left_hold = LeftSize'(RecordWords);
    end

    assign bus.word_out       = act_words[idx];
    assign bus.word_valid     = (state == STREAM);
    assign bus.rec_ready      = !hold_full;
    assign bus.words_left     = left_act + left_hold;
    assign bus.underrun_count = underrun;

endmodule

// File: tb/tb_record_serializer.sv
// tb/tb_record_serializer.sv - self-checking bench for record_serializer (8-bit words, 4-word records)
module tb_record_serializer;

    localparam int WS = 8;
    localparam int RW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    record_serializer_if #(.WordSize(WS), .RecordWords(RW)) bus ();

    record_serializer #(.WordSize(WS), .RecordWords(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rv;
        logic [31:0] data;
        logic        req;
        logic        wv;
        logic [7:0]  word;
        logic        chk_word;
        logic        rr;
        logic [3:0]  left;
    } vec_t;

    vec_t vecs [9];

    logic [31:0] mq [$];
    int          mpos;
    int          munder;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] data, input logic req);
        bus.rec_valid = rv;
        bus.rec_data  = data;
        bus.word_req  = req;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    function automatic logic [7:0] rec_word(input logic [31:0] r, input int i);
        return 8'((r >> (i * WS)) & 32'hFF);
    endfunction

    initial begin
        logic [7:0] exp_seq [8];
        logic [31:0] rdata;
        logic rv, rq, acc, pop;
        int exp_left;

        drive(1'b0, 32'h0, 1'b0);
        step();
        step();
        check("reset_word_valid", 64'(bus.word_valid), 64'd0);
        check("reset_rec_ready", 64'(bus.rec_ready), 64'd1);
        check("reset_words_left", 64'(bus.words_left), 64'd0);
        check("reset_word_out", 64'(bus.word_out), 64'd0);
        check("reset_underrun", 64'(bus.underrun_count), 64'd0);
        rst_n = 1'b1;
        step();

        // Back-to-back records with word_req held: eight words, no bubble.
        vecs[0] = '{1'b1, 32'h44332211, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 4'd4};
        vecs[1] = '{1'b1, 32'h88776655, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 4'd7};
        vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 4'd6};
        vecs[3] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 4'd5};
        vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 4'd4};
        vecs[5] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 4'd3};
        vecs[6] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 4'd2};
        vecs[7] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h88, 1'b1, 1'b1, 4'd1};
        vecs[8] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4'd0};

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].rv, vecs[i].data, vecs[i].req);
            step();
            check($sformatf("vec%0d_word_valid", i), 64'(bus.word_valid), 64'(vecs[i].wv));
            check($sformatf("vec%0d_rec_ready", i), 64'(bus.rec_ready), 64'(vecs[i].rr));
            check($sformatf("vec%0d_words_left", i), 64'(bus.words_left), 64'(vecs[i].left));
            if (vecs[i].chk_word)
                check($sformatf("vec%0d_word_out", i), 64'(bus.word_out), 64'(vecs[i].word));
        end
        check("vec_underrun", 64'(bus.underrun_count), 64'd0);

        // Third record offered while act and hold are both occupied.
        do_reset();
        drive(1'b1, 32'h44332211, 1'b0); step();
        drive(1'b1, 32'h88776655, 1'b0); step();
        check("full_rec_ready", 64'(bus.rec_ready), 64'd0);
        check("full_words_left", 64'(bus.words_left), 64'd8);
        drive(1'b1, 32'hCCBBAA99, 1'b0); step();
        check("full_stall_ready", 64'(bus.rec_ready), 64'd0);
        check("full_stall_left", 64'(bus.words_left), 64'd8);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'hCCBBAA99, 1'b1); step();
        end
        check("full_pop3_ready", 64'(bus.rec_ready), 64'd0);
        check("full_pop3_left", 64'(bus.words_left), 64'd5);
        check("full_pop3_word", 64'(bus.word_out), 64'h44);
        drive(1'b1, 32'hCCBBAA99, 1'b1); step();
        check("full_promote_ready", 64'(bus.rec_ready), 64'd1);
        check("full_promote_left", 64'(bus.words_left), 64'd4);
        drive(1'b1, 32'hCCBBAA99, 1'b0); step();
        check("full_third_taken_ready", 64'(bus.rec_ready), 64'd0);
        check("full_third_taken_left", 64'(bus.words_left), 64'd8);
        exp_seq = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        for (int k = 0; k < 8; k++) begin
            check($sformatf("drain_word%0d", k), 64'(bus.word_out), 64'(exp_seq[k]));
            check($sformatf("drain_valid%0d", k), 64'(bus.word_valid), 64'd1);
            drive(1'b0, 32'h0, 1'b1); step();
        end
        drive(1'b0, 32'h0, 1'b0);
        check("drain_empty_valid", 64'(bus.word_valid), 64'd0);
        check("drain_no_underrun", 64'(bus.underrun_count), 64'd0);

        // Underrun counting and saturation.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 1'b1); step();
        end
        check("underrun_3", 64'(bus.underrun_count), 64'd3);
        check("underrun_valid", 64'(bus.word_valid), 64'd0);
        for (int k = 0; k < 300; k++) step();
        check("underrun_sat", 64'(bus.underrun_count), 64'd255);
        drive(1'b0, 32'h0, 1'b0);

        // Asynchronous reset mid-record.
        do_reset();
        drive(1'b1, 32'h44332211, 1'b0); step();
        drive(1'b1, 32'h88776655, 1'b1); step();
        drive(1'b0, 32'h0, 1'b1); step();
        check("mid_word_before_rst", 64'(bus.word_out), 64'h33);
        drive(1'b0, 32'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.word_valid), 64'd0);
        check("mid_rst_left", 64'(bus.words_left), 64'd0);
        check("mid_rst_ready", 64'(bus.rec_ready), 64'd1);
        step();
        rst_n = 1'b1;
        step();
        drive(1'b1, 32'hDDCCBBAA, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0);
        check("post_rst_word0", 64'(bus.word_out), 64'hAA);
        check("post_rst_left", 64'(bus.words_left), 64'd4);

        // Randomized traffic against a record-queue reference model.
        do_reset();
        mq.delete();
        mpos = 0;
        munder = 0;
        for (int c = 0; c < 1500; c++) begin
            exp_left = (mq.size() > 0) ? (RW - mpos) + ((mq.size() == 2) ? RW : 0) : 0;
            check("rnd_word_valid", 64'(bus.word_valid), 64'(mq.size() > 0));
            check("rnd_rec_ready", 64'(bus.rec_ready), 64'(mq.size() < 2));
            check("rnd_words_left", 64'(bus.words_left), 64'(exp_left));
            check("rnd_underrun", 64'(bus.underrun_count), 64'(munder));
            if (mq.size() > 0)
                check("rnd_word_out", 64'(bus.word_out), 64'(rec_word(mq[0], mpos)));

            rv    = ($urandom_range(0, 1) == 1);
            rq    = ($urandom_range(0, 3) != 0);
            rdata = $urandom;
            drive(rv, rdata, rq);

            acc = rv && (mq.size() < 2);
            pop = rq && (mq.size() > 0);
            if (rq && mq.size() == 0 && munder < 255)
                munder++;
            if (pop) begin
                mpos++;
                if (mpos == RW) begin
                    void'(mq.pop_front());
                    mpos = 0;
                end
            end
            if (acc)
                mq.push_back(rdata);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
